// File: rtl/AHB_package.sv
// Shared AHB types and helpers for the generated interconnect.
package AHB_package;

    localparam int unsigned BEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } arb_state_e;

    // Burst length minus one; undefined-length INCR behaves like a single beat.
    function automatic logic [BEAT_W-1:0] burst_beats(input hburst_type b);
        logic [BEAT_W-1:0] n;
        case (b)
            WRAP4,  INCR4:  n = BEAT_W'(3);
            WRAP8,  INCR8:  n = BEAT_W'(7);
            WRAP16, INCR16: n = BEAT_W'(15);
            default:        n = BEAT_W'(0);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin select: search starts just after last_i and wraps.
module ahb_rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    input  logic [N-1:0]     excl_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [N-1:0]     cand_c;
    int unsigned      pos_c;
    logic [IDX_W-1:0] pos_idx_c;

    // First eligible requester in the rotated order wins.
    always_comb begin
        cand_c    = req_i & ~excl_i;
        gnt_o     = '0;
        idx_o     = '0;
        valid_o   = 1'b0;
        pos_c     = 0;
        pos_idx_c = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos_c     = (32'(last_i) + k) % N;
            pos_idx_c = IDX_W'(pos_c);
            if (!valid_o && cand_c[pos_idx_c]) begin
                valid_o          = 1'b1;
                gnt_o[pos_idx_c] = 1'b1;
                idx_o            = pos_idx_c;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: round-robin owner selection, burst locking, data-phase tracking.
module ahb_arbiter_slave
    import AHB_package::*;
#(
    parameter int unsigned SLAVE_X_MASTER_NUM = 4,
    parameter int unsigned IDX_W              = $clog2(SLAVE_X_MASTER_NUM)
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
    input  htrans_type                    htrans [SLAVE_X_MASTER_NUM],
    input  hburst_type                    hburst [SLAVE_X_MASTER_NUM],
    input  logic                          hready,
    output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
    output logic [IDX_W-1:0]              addr_idx,
    output logic                          hsel,
    output logic [IDX_W-1:0]              data_idx,
    output logic                          data_valid
);

    localparam int unsigned N = SLAVE_X_MASTER_NUM;

    arb_state_e        state_q;
    logic [N-1:0]      hgrant_q;
    logic [IDX_W-1:0]  addr_idx_q;
    logic [IDX_W-1:0]  data_idx_q;
    logic              data_valid_q;
    logic [BEAT_W-1:0] remain_q;
    logic [BEAT_W-1:0] remain_d;
    logic [IDX_W-1:0]  last_q;

    htrans_type        own_trans_c;
    hburst_type        own_burst_c;
    logic              own_c;
    logic              hsel_c;
    logic              accept_c;
    logic              rel_a_c;
    logic              rel_b_c;
    logic [N-1:0]      excl_c;
    logic [N-1:0]      pick_gnt_c;
    logic [IDX_W-1:0]  pick_idx_c;
    logic              pick_valid_c;

    // Owner view, beat counter update and release conditions.
    always_comb begin
        own_c       = (state_q == ST_OWN);
        own_trans_c = htrans[addr_idx_q];
        own_burst_c = hburst[addr_idx_q];
        hsel_c      = own_c && ((own_trans_c == NONSEQ) || (own_trans_c == SEQ));
        accept_c    = hready && hsel_c;
        remain_d    = remain_q;
        if (accept_c) begin
            if (own_trans_c == NONSEQ) begin
                remain_d = burst_beats(own_burst_c);
            end else if (remain_q != '0) begin
                remain_d = remain_q - BEAT_W'(1);
            end
        end
        // A defined burst ends on its last accepted beat; INCR never ends this way.
        rel_a_c = accept_c && (own_burst_c != INCR) && (remain_d == '0);
        // Owner went idle, or dropped its request with nothing outstanding.
        rel_b_c = own_c && !rel_a_c &&
                  ((own_trans_c == IDLE) || (!hreq[addr_idx_q] && (remain_q == '0)));
        // The finishing owner of a defined burst must not win the immediate handover.
        excl_c  = rel_a_c ? hgrant_q : '0;
    end

    ahb_rr_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (hreq),
        .last_i  (last_q),
        .excl_i  (excl_c),
        .gnt_o   (pick_gnt_c),
        .idx_o   (pick_idx_c),
        .valid_o (pick_valid_c)
    );

    // Ownership FSM and data-phase pipeline; everything frozen while hready is low.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q      <= ST_ARB;
            hgrant_q     <= '0;
            addr_idx_q   <= '0;
            data_idx_q   <= '0;
            data_valid_q <= 1'b0;
            remain_q     <= '0;
            last_q       <= IDX_W'(N - 1);
        end else if (hready) begin
            data_valid_q <= hsel_c;
            data_idx_q   <= addr_idx_q;
            remain_q     <= remain_d;
            case (state_q)
                ST_ARB: begin
                    if (pick_valid_c) begin
                        state_q    <= ST_OWN;
                        hgrant_q   <= pick_gnt_c;
                        addr_idx_q <= pick_idx_c;
                        last_q     <= pick_idx_c;
                        remain_q   <= '0;
                    end
                end
                ST_OWN: begin
                    if (rel_a_c || rel_b_c) begin
                        remain_q <= '0;
                        if (pick_valid_c) begin
                            hgrant_q   <= pick_gnt_c;
                            addr_idx_q <= pick_idx_c;
                            last_q     <= pick_idx_c;
                        end else begin
                            state_q  <= ST_ARB;
                            hgrant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_ARB;
                    hgrant_q <= '0;
                end
            endcase
        end
    end

    assign hgrant     = hgrant_q;
    assign addr_idx   = addr_idx_q;
    assign hsel       = hsel_c;
    assign data_idx   = data_idx_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Scoreboard bench for ahb_arbiter_slave (4 masters).
module tb_ahb_arbiter_slave;
    import AHB_package::*;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] aidx;
        logic       hsel;
        logic [1:0] didx;
        logic       dv;
    } obs_t;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hreq;
    htrans_type htrans_s [4];
    hburst_type hburst_s [4];
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] addr_idx;
    logic       hsel;
    logic [1:0] data_idx;
    logic       data_valid;

    obs_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(4)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hreq       (hreq),
        .htrans     (htrans_s),
        .hburst     (hburst_s),
        .hready     (hready),
        .hgrant     (hgrant),
        .addr_idx   (addr_idx),
        .hsel       (hsel),
        .data_idx   (data_idx),
        .data_valid (data_valid)
    );

    function automatic obs_t mk(input logic [3:0] g, input int unsigned a, input logic h,
                                input int unsigned d, input logic v);
        obs_t o;
        o.gnt  = g;
        o.aidx = 2'(a);
        o.hsel = h;
        o.didx = 2'(d);
        o.dv   = v;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.gnt  = hgrant;
        o.aidx = addr_idx;
        o.hsel = hsel;
        o.didx = data_idx;
        o.dv   = data_valid;
        return o;
    endfunction

    task automatic idle_all();
        hreq   = 4'b0000;
        hready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            htrans_s[m] = IDLE;
            hburst_s[m] = SINGLE;
        end
    endtask

    task automatic set_m(input int m, input logic req, input htrans_type t, input hburst_type b);
        hreq[m]     = req;
        htrans_s[m] = t;
        hburst_s[m] = b;
    endtask

    task automatic apply_reset();
        idle_all();
        hreset = 1'b1;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        hreset = 1'b1;
        idle_all();
        for (int m = 0; m < 4; m++) set_m(m, 1'b1, NONSEQ, SINGLE);
        exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
        repeat (2) @(posedge hclk);
        #1;
        got = sample();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset got=%b exp=%b", got, e);
        end
        idle_all();
        hreset = 1'b0;
    endtask

    task automatic test_single_pair();
        obs_t exp_t [5];
        obs_t got, e;
        exp_t = '{mk(4'b0000, 0, 0, 0, 0), mk(4'b0010, 1, 1, 0, 0), mk(4'b0100, 2, 1, 1, 1),
                  mk(4'b0000, 2, 0, 2, 1), mk(4'b0000, 2, 0, 2, 0)};
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            idle_all();
            if (c <= 1) set_m(1, 1'b1, NONSEQ, SINGLE);
            if (c <= 2) set_m(2, 1'b1, NONSEQ, SINGLE);
            exp_q.push_back(exp_t[c]);
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL single_pair c%0d got=%b exp=%b", c, got, e);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_incr4_handover();
        obs_t exp_t [8];
        obs_t got, e;
        exp_t = '{mk(4'b0000, 0, 0, 0, 0), mk(4'b0001, 0, 1, 0, 0), mk(4'b0001, 0, 1, 0, 1),
                  mk(4'b0001, 0, 1, 0, 1), mk(4'b0001, 0, 1, 0, 1), mk(4'b1000, 3, 1, 0, 1),
                  mk(4'b0000, 3, 0, 3, 1), mk(4'b0000, 3, 0, 3, 0)};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            idle_all();
            if (c <= 4) set_m(0, 1'b1, (c <= 1) ? NONSEQ : SEQ, INCR4);
            if (c <= 5) set_m(3, 1'b1, NONSEQ, SINGLE);
            exp_q.push_back(exp_t[c]);
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL incr4_handover c%0d got=%b exp=%b", c, got, e);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_wrap8_stall();
        obs_t got, e;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            idle_all();
            hready = !(c >= 2 && c <= 4);
            if (c <= 1)       set_m(1, 1'b1, NONSEQ, WRAP8);
            else if (c <= 11) set_m(1, 1'b1, SEQ, WRAP8);
            if (c == 0)       exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
            else if (c == 1)  exp_q.push_back(mk(4'b0010, 1, 1, 0, 0));
            else if (c <= 11) exp_q.push_back(mk(4'b0010, 1, 1, 1, 1));
            else if (c == 12) exp_q.push_back(mk(4'b0000, 1, 0, 1, 1));
            else              exp_q.push_back(mk(4'b0000, 1, 0, 1, 0));
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL wrap8_stall c%0d got=%b exp=%b", c, got, e);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_incr_busy_idle();
        obs_t exp_t [7];
        htrans_type seq_t [6];
        obs_t got, e;
        exp_t = '{mk(4'b0000, 0, 0, 0, 0), mk(4'b0100, 2, 1, 0, 0), mk(4'b0100, 2, 1, 2, 1),
                  mk(4'b0100, 2, 0, 2, 1), mk(4'b0100, 2, 1, 2, 0), mk(4'b0100, 2, 0, 2, 1),
                  mk(4'b0000, 2, 0, 2, 0)};
        seq_t = '{NONSEQ, NONSEQ, SEQ, BUSY, SEQ, IDLE};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            idle_all();
            if (c <= 5) set_m(2, (c <= 4), seq_t[c], INCR);
            exp_q.push_back(exp_t[c]);
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL incr_busy_idle c%0d got=%b exp=%b", c, got, e);
            end
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        obs_t got, e;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            idle_all();
            set_m(0, 1'b1, (c <= 1) ? NONSEQ : SEQ, INCR16);
            if (c == 0)      exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
            else if (c == 1) exp_q.push_back(mk(4'b0001, 0, 1, 0, 0));
            else             exp_q.push_back(mk(4'b0001, 0, 1, 0, 1));
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset_mid_burst c%0d got=%b exp=%b", c, got, e);
            end
            if (c < 5) begin
                @(posedge hclk);
                #1;
            end
        end
        // Asynchronous assertion between clock edges during beat 5.
        hreset = 1'b1;
        exp_q.push_back(mk(4'b0000, 0, 0, 0, 0));
        #1;
        got = sample();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_async got=%b exp=%b", got, e);
        end
        for (int m = 0; m < 4; m++) set_m(m, 1'b1, NONSEQ, SINGLE);
        @(posedge hclk);
        #1 hreset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back((r == 0) ? mk(4'b0000, 0, 0, 0, 0) : mk(4'b0001, 0, 1, 0, 0));
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset_regrant r%0d got=%b exp=%b", r, got, e);
            end
            @(posedge hclk);
            #1;
        end
        idle_all();
    endtask

    task automatic test_back_to_back();
        obs_t exp_t [6];
        obs_t got, e;
        exp_t = '{mk(4'b0000, 0, 0, 0, 0), mk(4'b0001, 0, 1, 0, 0), mk(4'b0010, 1, 1, 0, 1),
                  mk(4'b0100, 2, 1, 1, 1), mk(4'b1000, 3, 1, 2, 1), mk(4'b0001, 0, 1, 3, 1)};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            idle_all();
            for (int m = 0; m < 4; m++) set_m(m, 1'b1, NONSEQ, SINGLE);
            exp_q.push_back(exp_t[c]);
            #1;
            got = sample();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL back_to_back c%0d got=%b exp=%b", c, got, e);
            end
            @(posedge hclk);
            #1;
        end
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        hreset = 1'b1;
        test_reset();
        test_single_pair();
        test_incr4_handover();
        test_wrap8_stall();
        test_incr_busy_idle();
        test_reset_mid_burst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
